decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage of the in-order RISC-V pipeline. Sits between fetch and execute, and drives the read-address side of `register_file`. Captures operands into the ID/EX pipeline register and generates immediates. A per-register pending-write scoreboard stalls fetch on data hazards and clears as writeback retires results.

## Interface
- `NOP_INSN`, default 32'h0000_0013: instruction word held in ID/EX when empty.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_valid` / `if_ready`  in / out  1  fetch handshake; accept = `if_valid & if_ready`.
- `if_pc`, `if_insn`  in  32  fetched PC and instruction.
- `flush`  in  1  wrong-path kill from execute.
- `rf_addr_rs1`, `rf_addr_rs2`  out  5  combinational `if_insn[19:15]`, `if_insn[24:20]`.
- `rf_data_rs1`, `rf_data_rs2`  in  32  combinational register-file read data.
- `wb_we`, `wb_rd`, `wb_data`  in  1/5/32  writeback port; same signals drive `register_file` write.
- `ex_valid` / `ex_ready`  out / in  1  execute handshake.
- `ex_pc`, `ex_insn`, `ex_rs1_val`, `ex_rs2_val`, `ex_imm`  out  32  ID/EX payload.
- `ex_rd`  out  5; `ex_reg_write`, `ex_is_load`  out  1.

## Operation
- Source use by opcode:
  - LUI, AUIPC and JAL use no source.
  - OP-IMM, LOAD and JALR use rs1.
  - OP, STORE and BRANCH use rs1 and rs2.
  - `reg_write` = opcode is not STORE/BRANCH and rd≠0.
- Immediates: I/S/B/U/J formats, sign-extended from bit 31. B and J have bit 0 = 0. U is `insn[31:12]<<12`.
- Scoreboard `pending[31:1]`; x0 is never pending.
  - Set bit rd on accept with `reg_write`.
  - Clear bit `wb_rd` when `wb_we` is asserted.
  - Set wins if set and clear hit the same index in one cycle.
- Hazard, evaluated when `if_valid`:
  - Any used source has its pending bit set and is not bypassable, or
  - the destination has its pending bit set (WAW).
- Advance when `!ex_valid | ex_ready`.
- `if_ready` = advance & !hazard, or 1 when `flush` is asserted.
- On advance:
  - ID/EX loads the accepted instruction with `ex_valid`=1.
  - If nothing is accepted, ID/EX loads a bubble: `ex_valid`=0, `ex_insn`=`NOP_INSN`.
- `flush`: incoming instruction is dropped and no scoreboard bit is set. ID/EX loads a bubble if advancing, otherwise holds.
- Operand refresh: while `ex_valid & !ex_ready`, a `wb_we` write matching the held rs1/rs2 field (≠0) overwrites `ex_rs1_val`/`ex_rs2_val`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on `ex_*` after edge N.
- Register-file read is same-cycle combinational.
- A pending bit cleared at edge N unblocks the stall in cycle N+1; the register file is updated at that same edge.
- Reset values:
  - `ex_valid`=0, `ex_insn`=`NOP_INSN`, all other `ex_*`=0.
  - `pending`=0.
  - `if_ready`=1 in the first cycle after reset.
- Reset asserted mid-stall discards the held entry and all pending bits.
- `flush` takes priority over hazard, accept and refresh of the incoming instruction.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A used source that is pending and is being written this cycle (`wb_we`, `wb_rd`==src) takes `wb_data`, with no stall.
- Not defined:
  - That source stalls; the instruction issues in the next cycle, reading the register file.
- WAW stall is identical in both builds.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`, `OP_IMM`, `OP_REG`, `OP_SYSTEM`;
  - `NOP_INSN`;
  - register-index width 5 and `XLEN` 32.
- Sub-module `imm_gen`: combinational, `insn` in, `imm` out. Scoreboard and ID/EX register stay in `decode_stage`.

## Test plan
- Reset, then ADDI x5,x0,7 (32'h0070_0293) → next cycle `ex_valid`=1, `ex_imm`=7, `ex_rd`=5, `ex_reg_write`=1; `pending[5]`=1.
- ADD x6,x5,x5 while `pending[5]`, no WB → `if_ready`=0 and bubble issued. WB x5=7 arrives:
  - bypass build: issues the same cycle with `ex_rs1_val`=`ex_rs2_val`=7;
  - no-bypass build: issues one cycle later with the same values.
- LW x1 in ID/EX with `ex_ready`=0 held 3 cycles, followed by SW with rs2=x1 → `if_ready`=0 throughout; ID/EX stable.
- `flush` with a valid ADDI x9 → `ex_valid`=0 after the edge, `pending[9]`=0.
- ID/EX holding rs1=x3 stalled; `wb_we`, `wb_rd`=3, `wb_data`=32'hDEAD_BEEF → `ex_rs1_val`=32'hDEAD_BEEF next cycle.
- BEQ with imm −4 → `ex_imm`=32'hFFFF_FFFC; `ex_reg_write`=0, no pending bit set.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcode constants, widths and immediate-format lookup
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // R-type and unrecognised opcodes carry no immediate and decode to zero.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
      OP_STORE:                            return FMT_S;
      OP_BRANCH:                           return FMT_B;
      OP_LUI, OP_AUIPC:                    return FMT_U;
      OP_JAL:                              return FMT_J;
      default:                             return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate generator for I/S/B/U/J instruction formats
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt(insn[6:0]))
      FMT_I:   imm = {{20{insn[31]}}, insn[31:20]};
      FMT_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      FMT_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      FMT_U:   imm = {insn[31:12], 12'h000};
      FMT_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with pending-write scoreboard and ID/EX register
// Optional writeback bypass of pending sources: DECODE_WB_BYPASS_EN
module decode_stage #(
  parameter logic [31:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_insn,
  input  logic        flush,
  output logic [4:0]  rf_addr_rs1,
  output logic [4:0]  rf_addr_rs2,
  input  logic [31:0] rf_data_rs1,
  input  logic [31:0] rf_data_rs2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_insn,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_is_load
);

  import riscv_pkg::*;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              use_rs1, use_rs2, reg_write;
  logic [31:0]       pending, pending_next;
  logic              byp_rs1, byp_rs2;
  logic              hazard, advance, accept;
  logic [XLEN-1:0]   rs1_val, rs2_val, imm;

  assign opcode      = if_insn[6:0];
  assign rs1         = if_insn[19:15];
  assign rs2         = if_insn[24:20];
  assign rd          = if_insn[11:7];
  assign rf_addr_rs1 = rs1;
  assign rf_addr_rs2 = rs2;

  assign use_rs1   = opcode inside {OP_IMM, OP_LOAD, OP_JALR, OP_REG, OP_STORE, OP_BRANCH};
  assign use_rs2   = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
  assign reg_write = !(opcode inside {OP_STORE, OP_BRANCH}) && (rd != '0);

`ifdef DECODE_WB_BYPASS_EN
  assign byp_rs1 = wb_we && (wb_rd == rs1) && (rs1 != '0);
  assign byp_rs2 = wb_we && (wb_rd == rs2) && (rs2 != '0);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  // WAW stalls even when the older write retires this cycle, in both builds.
  assign hazard = if_valid && ((use_rs1 && pending[rs1] && !byp_rs1) ||
                               (use_rs2 && pending[rs2] && !byp_rs2) ||
                               (reg_write && pending[rd]));

  assign advance  = !ex_valid || ex_ready;
  assign if_ready = flush || (advance && !hazard);
  assign accept   = if_valid && if_ready && !flush;

  assign rs1_val = byp_rs1 ? wb_data : rf_data_rs1;
  assign rs2_val = byp_rs2 ? wb_data : rf_data_rs2;

  imm_gen u_imm_gen (
    .insn (if_insn),
    .imm  (imm)
  );

  // Set is applied after clear so a same-index collision leaves the bit pending.
  always_comb begin
    pending_next = pending;
    if (wb_we) pending_next[wb_rd] = 1'b0;
    if (accept && reg_write) pending_next[rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_insn      <= NOP_INSN;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else begin
      pending <= pending_next;
      if (advance) begin
        if (accept) begin
          ex_valid     <= 1'b1;
          ex_pc        <= if_pc;
          ex_insn      <= if_insn;
          ex_rs1_val   <= rs1_val;
          ex_rs2_val   <= rs2_val;
          ex_imm       <= imm;
          ex_rd        <= rd;
          ex_reg_write <= reg_write;
          ex_is_load   <= (opcode == OP_LOAD);
        end else begin
          ex_valid     <= 1'b0;
          ex_pc        <= '0;
          ex_insn      <= NOP_INSN;
          ex_rs1_val   <= '0;
          ex_rs2_val   <= '0;
          ex_imm       <= '0;
          ex_rd        <= '0;
          ex_reg_write <= 1'b0;
          ex_is_load   <= 1'b0;
        end
      end else if (wb_we && (wb_rd != '0)) begin
        // Held entry keeps its operands current while execute back-pressures.
        if (wb_rd == ex_insn[19:15]) ex_rs1_val <= wb_data;
        if (wb_rd == ex_insn[24:20]) ex_rs2_val <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized decode_stage bench against a behavioural reference model
module tb_decode_stage;
  import riscv_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] I_ADDI5 = 32'h0070_0293;
  localparam logic [31:0] I_ADD6  = 32'h0052_8333;
  localparam logic [31:0] I_LW1   = 32'h0000_2083;
  localparam logic [31:0] I_SW1   = 32'h0010_2023;
  localparam logic [31:0] I_ADDI4 = 32'h0011_8213;
  localparam logic [31:0] I_ADDI9 = 32'h0090_0493;
  localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;

  logic        clock = 1'b0;
  logic        reset, if_valid, if_ready, flush, wb_we, ex_valid, ex_ready;
  logic        ex_reg_write, ex_is_load;
  logic [31:0] if_pc, if_insn, rf_data_rs1, rf_data_rs2, wb_data;
  logic [31:0] ex_pc, ex_insn, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  rf_addr_rs1, rf_addr_rs2, wb_rd, ex_rd;

  logic [31:0] regs [32];
  bit          pend [32];
  logic        m_valid, m_rw, m_ld, last_rdy;
  logic [31:0] m_pc, m_insn, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  logic [6:0]  ops [11];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clock = ~clock;

  assign rf_data_rs1 = regs[rf_addr_rs1];
  assign rf_data_rs2 = regs[rf_addr_rs2];

  decode_stage dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_insn(if_insn), .flush(flush),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_insn(ex_insn),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        v = int'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      OP_STORE: begin
        v = int'(i[31:25]) * 32 + int'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      OP_BRANCH: begin
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      OP_LUI, OP_AUIPC: return i & 32'hFFFF_F000;
      OP_JAL: begin
        v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit ref_use1(input logic [6:0] op);
    return op inside {OP_IMM, OP_LOAD, OP_JALR, OP_REG, OP_STORE, OP_BRANCH};
  endfunction

  function automatic bit ref_use2(input logic [6:0] op);
    return op inside {OP_REG, OP_STORE, OP_BRANCH};
  endfunction

  function automatic bit ref_rw(input logic [31:0] i);
    return !(i[6:0] inside {OP_STORE, OP_BRANCH}) && (i[11:7] != 5'd0);
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_pc = '0; m_insn = NOP_INSN; m_rs1 = '0; m_rs2 = '0;
    m_imm = '0; m_rd = '0; m_rw = 1'b0; m_ld = 1'b0;
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, advance model, check ID/EX.
  task automatic step(input bit v, input logic [31:0] insn, input bit fl, input bit er,
                      input bit we, input logic [4:0] wrd, input logic [31:0] wd, input bit rst);
    bit          adv, haz, exp_rdy, acc;
    logic [4:0]  s1, s2, d;
    logic [31:0] v1, v2, pc;
    pc = $urandom & 32'hFFFF_FFFC;
    if_valid = v; if_pc = pc; if_insn = insn; flush = fl; ex_ready = er;
    wb_we = we; wb_rd = wrd; wb_data = wd; reset = rst;
    #3;
    s1 = insn[19:15]; s2 = insn[24:20]; d = insn[11:7];
    check_eq("rf_addr_rs1", 32'(rf_addr_rs1), 32'(s1));
    check_eq("rf_addr_rs2", 32'(rf_addr_rs2), 32'(s2));
    adv = !m_valid || er;
    haz = v && ((ref_use1(insn[6:0]) && pend[s1] && !(BYP && we && wrd == s1)) ||
                (ref_use2(insn[6:0]) && pend[s2] && !(BYP && we && wrd == s2)) ||
                (ref_rw(insn) && pend[d]));
    exp_rdy = fl || (adv && !haz);
    last_rdy = if_ready;
    if (!rst) check_eq("if_ready", 32'(if_ready), 32'(exp_rdy));
    acc = v && exp_rdy && !fl;
    v1 = (BYP && we && wrd == s1 && s1 != 0) ? wd : regs[s1];
    v2 = (BYP && we && wrd == s2 && s2 != 0) ? wd : regs[s2];
    @(posedge clock);
    #1;
    if (we && wrd != 0) regs[wrd] = wd;
    if (rst) begin
      model_bubble();
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    end else begin
      if (adv) begin
        if (acc) begin
          m_valid = 1'b1; m_pc = pc; m_insn = insn; m_rs1 = v1; m_rs2 = v2;
          m_imm = ref_imm(insn); m_rd = d; m_rw = ref_rw(insn); m_ld = (insn[6:0] == OP_LOAD);
        end else begin
          model_bubble();
        end
      end else if (we && wrd != 0) begin
        if (wrd == m_insn[19:15]) m_rs1 = wd;
        if (wrd == m_insn[24:20]) m_rs2 = wd;
      end
      if (we) pend[wrd] = 1'b0;
      if (acc && ref_rw(insn)) pend[d] = 1'b1;
      pend[0] = 1'b0;
    end
    check_eq("ex_valid", 32'(ex_valid), 32'(m_valid));
    check_eq("ex_pc", ex_pc, m_pc);
    check_eq("ex_insn", ex_insn, m_insn);
    check_eq("ex_rs1_val", ex_rs1_val, m_rs1);
    check_eq("ex_rs2_val", ex_rs2_val, m_rs2);
    check_eq("ex_imm", ex_imm, m_imm);
    check_eq("ex_rd", 32'(ex_rd), 32'(m_rd));
    check_eq("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
    check_eq("ex_is_load", 32'(ex_is_load), 32'(m_ld));
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  wr;
    logic [4:0]  plist [$];
    bit          we;

    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
            OP_IMM, OP_REG, OP_SYSTEM, 7'b1111111};
    for (int r = 0; r < 32; r++) begin
      regs[r] = (r == 0) ? 32'h0 : $urandom;
      pend[r] = 1'b0;
    end
    model_bubble();

    step(0, NOP_INSN, 0, 1, 0, 5'd0, 32'h0, 1);
    step(0, NOP_INSN, 0, 1, 0, 5'd0, 32'h0, 1);

    step(1, I_ADDI5, 0, 1, 0, 5'd0, 32'h0, 0);
    check_eq("post_reset_ready", 32'(last_rdy), 32'd1);
    check_eq("addi_valid", 32'(ex_valid), 32'd1);
    check_eq("addi_imm", ex_imm, 32'd7);
    check_eq("addi_rd", 32'(ex_rd), 32'd5);
    check_eq("addi_reg_write", 32'(ex_reg_write), 32'd1);

    step(1, I_ADD6, 0, 1, 0, 5'd0, 32'h0, 0);
    check_eq("raw_stall_ready", 32'(last_rdy), 32'd0);
    check_eq("raw_stall_bubble", 32'(ex_valid), 32'd0);
    step(1, I_ADD6, 0, 1, 1, 5'd5, 32'd7, 0);
`ifndef DECODE_WB_BYPASS_EN
    check_eq("nobyp_still_bubble", 32'(ex_valid), 32'd0);
    step(1, I_ADD6, 0, 1, 0, 5'd0, 32'h0, 0);
`endif
    check_eq("raw_issue_valid", 32'(ex_valid), 32'd1);
    check_eq("raw_rs1", ex_rs1_val, 32'd7);
    check_eq("raw_rs2", ex_rs2_val, 32'd7);
    step(0, NOP_INSN, 0, 1, 1, 5'd6, 32'h11, 0);

    step(1, I_LW1, 0, 1, 0, 5'd0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, I_SW1, 0, 0, 0, 5'd0, 32'h0, 0);
      check_eq("load_use_ready", 32'(last_rdy), 32'd0);
      check_eq("load_hold_insn", ex_insn, I_LW1);
    end
    step(0, NOP_INSN, 0, 1, 1, 5'd1, 32'h55, 0);

    step(1, I_ADDI4, 0, 1, 0, 5'd0, 32'h0, 0);
    step(0, NOP_INSN, 0, 0, 1, 5'd3, 32'hDEAD_BEEF, 0);
    check_eq("refresh_rs1", ex_rs1_val, 32'hDEAD_BEEF);
    step(0, NOP_INSN, 0, 1, 1, 5'd4, 32'h44, 0);

    step(1, I_ADDI9, 1, 1, 0, 5'd0, 32'h0, 0);
    check_eq("flush_bubble", 32'(ex_valid), 32'd0);
    step(1, I_ADDI9, 0, 1, 0, 5'd0, 32'h0, 0);
    check_eq("flush_no_pending", 32'(last_rdy), 32'd1);
    step(0, NOP_INSN, 0, 1, 1, 5'd9, 32'h99, 0);

    step(1, I_BEQ, 0, 1, 0, 5'd0, 32'h0, 0);
    check_eq("beq_imm", ex_imm, 32'hFFFF_FFFC);
    check_eq("beq_reg_write", 32'(ex_reg_write), 32'd0);

    step(1, I_LW1, 0, 1, 0, 5'd0, 32'h0, 0);
    step(1, I_SW1, 0, 0, 0, 5'd0, 32'h0, 0);
    step(1, I_SW1, 0, 0, 0, 5'd0, 32'h0, 1);
    check_eq("reset_drop_valid", 32'(ex_valid), 32'd0);
    step(1, I_LW1, 0, 1, 0, 5'd0, 32'h0, 0);
    check_eq("reset_clear_pending", 32'(last_rdy), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 10)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      plist.delete();
      for (int r = 1; r < 32; r++) if (pend[r]) plist.push_back(5'(r));
      we = (plist.size() > 0) && ($urandom_range(0, 1) == 1);
      wr = we ? plist[$urandom_range(0, plist.size() - 1)] : 5'($urandom);
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, we, wr, $urandom, c == 1500);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
